bin2bcd_display: RTL
====================

BIN2BCD_DISPLAY -- requirements
Module: bin2bcd_display

Interface
REQ-001 SHALL have parameter WIDTH, default 7, binary input width (4..20).
REQ-002 SHALL have parameter DIGITS, default 3, number of decimal digits/displays (1..6).
REQ-003 SHALL have port Clock  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request conversion of bin; honoured only when busy=0.
REQ-006 SHALL have port bin  input  WIDTH  unsigned binary value, sampled on the accepting edge only.
REQ-007 SHALL have port blank_lz  input  1  1 = blank leading zero digits (live, not latched).
REQ-008 SHALL have port busy  output  1  conversion in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when results update.
REQ-010 SHALL have port overflow  output  1  last value was >= 10^DIGITS.
REQ-011 SHALL have port bcd  output  4*DIGITS  packed BCD result, digit 0 (units) in bits [3:0].
REQ-012 SHALL have port HEX  output  7*DIGITS  active-low 7-segment patterns, digit i in bits [7i+6:7i], segment order g..a.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-014 SHALL, in IDLE or DONE with start=1, load bin into shift register, clear BCD accumulator and enter SHIFT.
REQ-015 SHALL perform one double-dabble step per SHIFT cycle: add 3 to each BCD digit >= 5, then shift left one bit, MSB of bin first.
REQ-016 SHALL leave SHIFT after exactly WIDTH steps and enter DONE.
REQ-017 SHALL assert busy exactly in the WIDTH SHIFT cycles; start sampled while busy=1 is ignored, no queueing.
REQ-018 SHALL assert done for exactly the DONE cycle, WIDTH+1 cycles after the accepting edge; bcd, HEX, overflow update on the same edge done rises.
REQ-019 SHALL hold bcd, HEX, overflow stable between done pulses.
REQ-020 SHALL accept start during DONE (back-to-back conversions, period WIDTH+1 cycles).
REQ-021 SHALL set overflow when any carry leaves the top digit during conversion; bcd then holds the low DIGITS decimal digits.
REQ-022 SHALL drive every digit of HEX to dash (7'b0111111) while overflow=1, regardless of blank_lz.
REQ-023 SHALL, when blank_lz=1 and overflow=0, blank (7'b1111111) digit i>0 if digit i and all higher digits are zero; digit 0 never blanked.
REQ-024 SHALL map BCD 0-9 to the standard active-low patterns (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000); other codes blank.
REQ-025 SHALL compute HEX combinationally from registered bcd, overflow and blank_lz.

Reset
REQ-026 SHALL on Reset=1, asynchronously: state IDLE, busy=0, done=0, overflow=0, bcd=0, HEX all 7'b1111111 (display dark, blanking overridden until first done).
REQ-027 SHALL abort any conversion on Reset mid-operation; no done pulse for the aborted request.
REQ-028 SHALL accept start on the first rising edge after Reset deasserts.

Structure
REQ-029 SHALL place segment constants (digit patterns, BLANK, DASH) and FSM state encodings in a shared package/include.
REQ-030 SHALL instantiate sub-module seg7_decoder (4-bit BCD in, 7-bit active-low out) once per digit via generate.
REQ-031 SHALL size the BCD accumulator 4*DIGITS bits plus an overflow sticky bit; no dividers or modulo operators.

Verification
REQ-032 SHALL cover: WIDTH=7, DIGITS=3, bin=127, start pulse -> done 8 cycles later, bcd=12'h127, HEX2=1111001, HEX1=0100100, HEX0=1111000, overflow=0.
REQ-033 SHALL cover: bin=5, blank_lz=1 -> HEX2=HEX1=1111111, HEX0=0010010; toggle blank_lz=0 -> HEX2=HEX1=1000000 with no new done.
REQ-034 SHALL cover: WIDTH=10, DIGITS=3, bin=1000 -> overflow=1, bcd=12'h000, all HEX=0111111; then bin=999 -> overflow=0, bcd=12'h999.
REQ-035 SHALL cover: start re-pulsed with bin=3 while busy -> ignored, result equals first request; start in DONE cycle -> second done exactly 8 cycles later.
REQ-036 SHALL cover: Reset asserted 3 cycles into conversion -> busy=0, HEX all 1111111 immediately, no done pulse.
REQ-037 SHALL cover: exhaustive sweep bin=0..127 (WIDTH=7) compared against integer div/mod model for bcd and HEX.

Source files
------------

// File: rtl/bin2bcd_display_pkg.sv
// bin2bcd_display_pkg: FSM state encoding and active-low 7-segment patterns
package bin2bcd_display_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
endpackage

// File: rtl/bin2bcd_display_if.sv
// bin2bcd_display_if: request/result bundle between a client and the converter
interface bin2bcd_display_if #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  blank_lz;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   HEX;
  modport master (output start, bin, blank_lz, input busy, done, overflow, bcd, HEX);
  modport slave  (input start, bin, blank_lz, output busy, done, overflow, bcd, HEX);
endinterface

// File: rtl/bin2bcd_display_seg7_decoder.sv
// seg7_decoder: one BCD digit to an active-low g..a pattern, non-decimal codes dark
module seg7_decoder
  import bin2bcd_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/bin2bcd_display.sv
// bin2bcd_display: serial double-dabble binary-to-BCD converter driving active-low 7-segment displays
module bin2bcd_display
  import bin2bcd_display_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 3
) (
  input logic Clock,
  input logic Reset,
  bin2bcd_display_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t              r_state, w_next;
  logic                w_accept, w_last, w_carry, w_busy, w_done;
  logic [WIDTH-1:0]    r_sh;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_acc, w_adj, w_acc, r_bcd;
  logic                r_sticky, r_ovf, r_valid;
  logic [7*DIGITS-1:0] w_seg, w_hex;
  logic [DIGITS:0]     w_lead;
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_accept = bus.start && r_state != SHIFT;
    w_last   = r_cnt == CW'(WIDTH - 1);
    w_next   = w_accept ? SHIFT : (r_state == SHIFT && !w_last) ? SHIFT : (r_state == SHIFT) ? DONE : IDLE;
    w_busy   = r_state == SHIFT;
    w_done   = r_state == DONE;
  end
  always_comb begin
    w_adj = '0;
    for (int k = 0; k < DIGITS; k++)
      w_adj[4*k+:4] = (r_acc[4*k+:4] >= 4'd5) ? r_acc[4*k+:4] + 4'd3 : r_acc[4*k+:4];
    {w_carry, w_acc} = {w_adj, r_sh[WIDTH-1]};
  end
  // results are published on the last shift edge so they appear together with done
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sh     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_sticky <= 1'b0;
      r_bcd    <= '0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
    end else if (w_accept) begin
      r_sh     <= bus.bin;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_sticky <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_sh     <= {r_sh[WIDTH-2:0], 1'b0};
      r_cnt    <= r_cnt + 1'b1;
      r_acc    <= w_acc;
      r_sticky <= r_sticky | w_carry;
      if (w_last) begin
        r_bcd   <= w_acc;
        r_ovf   <= r_sticky | w_carry;
        r_valid <= 1'b1;
      end
    end
  end
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    seg7_decoder u_dec (.i_bcd(r_bcd[4*d+:4]), .o_seg(w_seg[7*d+:7]));
  end
  // w_lead[k]: digit k and every digit above it are zero
  always_comb begin
    w_lead         = '0;
    w_hex          = '0;
    w_lead[DIGITS] = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_lead[k]      = w_lead[k+1] && r_bcd[4*k+:4] == 4'd0;
      w_hex[7*k+:7]  = !r_valid ? SEG_BLANK : r_ovf ? SEG_DASH :
                       (bus.blank_lz && k > 0 && w_lead[k]) ? SEG_BLANK : w_seg[7*k+:7];
    end
  end
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.overflow = r_ovf;
  assign bus.bcd      = r_bcd;
  assign bus.HEX      = w_hex;
endmodule
